keypad_scan_module: RTL
=======================

# keypad_scan_module

Scans a 4x4 matrix keypad by driving one column low at a time and sensing the rows. It debounces the result and reports one key code per press. It is the input-side counterpart to the time-multiplexed 7-segment display driver: columns are scanned the same way that driver walks its digit selects, and the decoded code feeds the game logic that produces the displayed `data` and `tries` values.

## Interface
Parameters:
- T_SCAN, 16'd50000: clock cycles per column slot (1 ms at 50 MHz); legal range 4..65535.
- DEB_CNT, 4'd4: consecutive matching frames needed to accept a press or a release; legal range 2..15.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST_n  in  1  reset, asynchronous, active-low.
- Row_In  in  4  row sense, active-low, external pull-ups, asynchronous to CLK.
- Col_Out  out  4  column drive, active-low, exactly one bit low at all times.
- Key_Code  out  4  code of the last accepted key, = 4*row + col.
- Key_Valid  out  1  one-cycle pulse when a press is accepted.
- Key_Held  out  1  level, high from press acceptance until release acceptance.

## Operation
- Row_In passes through a 2-flop synchronizer before any use.
- Slot counter (16 bit) counts 0..T_SCAN-1 and wraps. `tick` = counter at T_SCAN-1.
- Column index 0..3 advances on each tick and wraps 3->0. Col_Out drive sequence: 1110, 1101, 1011, 0111.
- Synchronized rows are sampled on tick, before the column advances, so there is T_SCAN-1 cycles of settle time.
- Frame = 4 slots. The frame accumulator records, per frame:
  - the number of low row bits summed over all 4 slots, saturating at 2;
  - the code of the pressed key, taken from the lowest row index within the lowest column.
- Frame classification, evaluated at the tick of column 3:
  - NONE: count is 0.
  - SINGLE(k): count is 1, with code k.
  - MULTI: count is 2 or more; treated as NONE for acceptance (ghosting guard).
- FSM, updated only at end of frame, with a 4-bit frame counter `cnt`:
  - IDLE: SINGLE(k) -> DEBOUNCE, cand=k, cnt=1. Otherwise stay.
  - DEBOUNCE:
    - SINGLE(cand) and cnt+1==DEB_CNT -> PRESSED; Key_Code<=cand, Key_Valid=1 for one cycle, Key_Held<=1.
    - SINGLE(cand) otherwise -> cnt+1.
    - NONE, MULTI or SINGLE(other) -> IDLE, cnt=0.
  - PRESSED: NONE or MULTI -> RELEASE, cnt=1. SINGLE(any) -> stay. Key_Code does not change.
  - RELEASE:
    - NONE or MULTI with cnt+1==DEB_CNT -> IDLE, Key_Held<=0.
    - NONE or MULTI otherwise -> cnt+1.
    - SINGLE(any) -> PRESSED, cnt=0, no new Key_Valid.
- A second key pressed while a key is held is never reported. A new press requires a full release first.

## Timing
- Reset values (asynchronous on RST_n low): Col_Out=4'b1110, slot counter 0, column index 0, frame accumulator cleared, FSM IDLE, cnt 0, Key_Code 4'h0, Key_Valid 0, Key_Held 0.
- Scanning resumes the first cycle after RST_n deasserts. The first frame begins at column 0.
- Key_Valid and Key_Held rise in the cycle after the column-3 tick of the accepting frame; Key_Code updates in that same cycle.
- Key_Valid is exactly one cycle wide.
- Press latency from stable contact: between DEB_CNT and DEB_CNT+1 frames (partial first frame), plus 3 cycles of synchronizer and register delay.
- Release latency is the same, on Key_Held falling.
- Col_Out changes in the cycle after each tick; no two columns are ever low together.

## Test plan
All scenarios use T_SCAN=8 and DEB_CNT=3, so one frame is 32 cycles. The bench keypad model drives Row_In[r]=0 when Col_Out[c]=0 and key (r,c) is pressed.
- Reset: assert RST_n low at cycle 13 while Col_Out=1101 -> immediately Col_Out=1110, Key_Valid=0, Key_Held=0, Key_Code=0. After release, Col_Out walks 1110, 1101, 1011, 0111, changing every 8 cycles.
- Clean press of row 1, col 2, held for 6 frames -> exactly one Key_Valid pulse, Key_Code=4'd6, Key_Held=1, between frame boundaries 3 and 4 after contact.
- Bounce: key (0,0) pressed and released on alternating frames for 10 frames -> Key_Valid never asserts and Key_Held stays 0.
- Ghost: keys (0,1) and (2,3) held together for 6 frames -> no Key_Valid. Then release (2,3) -> one Key_Valid with Key_Code=4'd1 after 3 single-key frames.
- Release and re-touch: key 6 accepted, released for 2 frames, pressed again -> Key_Held stays 1 and no second pulse. Then released for 3 frames -> Key_Held=0. Pressing 6 again -> new Key_Valid pulse.
- Reset mid-PRESSED: while Key_Held=1, pulse RST_n low for 1 cycle with key still pressed -> Key_Held=0 and Key_Code=0 at once. A fresh Key_Valid (Key_Code=6) follows 3 frames after reset release.

Source files
------------

// File: rtl/keypad_scan_module_if.sv
// Keypad scanner signal bundle: matrix row/column lines plus the decoded key outputs.
interface keypad_scan_module_if;
    logic [3:0] Row_In;
    logic [3:0] Col_Out;
    logic [3:0] Key_Code;
    logic       Key_Valid;
    logic       Key_Held;

    // Scanner side: senses rows, drives columns and reports keys.
    modport master (
        input  Row_In,
        output Col_Out,
        output Key_Code,
        output Key_Valid,
        output Key_Held
    );

    // Keypad / consumer side.
    modport slave (
        output Row_In,
        input  Col_Out,
        input  Key_Code,
        input  Key_Valid,
        input  Key_Held
    );
endinterface

// File: rtl/keypad_scan_module.sv
// 4x4 matrix keypad scanner: walks one active-low column per slot, accumulates the
// rows seen over a 4-slot frame, and debounces single-key frames into one code per press.
module keypad_scan_module #(
    parameter logic [15:0] T_SCAN  = 16'd50000,
    parameter logic [3:0]  DEB_CNT = 4'd4
) (
    input  logic                        CLK,
    input  logic                        RST_n,
    keypad_scan_module_if.master        kp
);

    typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

    logic [3:0]  r_row_meta;
    logic [3:0]  r_row_sync;
    logic [15:0] r_slot;
    logic [1:0]  r_col;
    logic [1:0]  r_acc_cnt;
    logic [3:0]  r_acc_code;
    state_e      r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_cand;
    logic [3:0]  r_key_code;
    logic        r_key_valid;
    logic        r_key_held;

    logic        w_tick;
    logic        w_frame_end;
    logic [3:0]  w_row_low;
    logic [2:0]  w_slot_pop;
    logic [2:0]  w_acc_sum;
    logic [1:0]  w_acc_cnt_next;
    logic [1:0]  w_slot_row;
    logic        w_slot_any;
    logic [3:0]  w_acc_code_next;
    logic        w_single;
    state_e      w_state_d;
    logic [3:0]  w_cnt_d;
    logic [3:0]  w_cand_d;
    logic [3:0]  w_code_d;
    logic        w_valid_d;
    logic        w_held_d;

    assign w_tick      = (r_slot == T_SCAN - 16'd1);
    assign w_frame_end = w_tick && (r_col == 2'd3);

    // Two-flop synchronizer for the asynchronous row inputs; idle level is all-high.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= kp.Row_In;
            r_row_sync <= r_row_meta;
        end
    end

    // Slot counter and column index; the column advances on each slot tick.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_slot <= 16'd0;
            r_col  <= 2'd0;
        end else if (w_tick) begin
            r_slot <= 16'd0;
            r_col  <= r_col + 2'd1;
        end else begin
            r_slot <= r_slot + 16'd1;
        end
    end

    assign kp.Col_Out = ~(4'b0001 << r_col);

    assign w_row_low  = ~r_row_sync;
    assign w_slot_any = |w_row_low;
    assign w_slot_pop = {2'b00, w_row_low[0]} + {2'b00, w_row_low[1]}
                      + {2'b00, w_row_low[2]} + {2'b00, w_row_low[3]};
    assign w_acc_sum  = {1'b0, r_acc_cnt} + w_slot_pop;
    assign w_acc_cnt_next = (w_acc_sum >= 3'd2) ? 2'd2 : w_acc_sum[1:0];

    // Lowest low row index within the current slot.
    always_comb begin
        w_slot_row = 2'd0;
        if (w_row_low[3]) w_slot_row = 2'd3;
        if (w_row_low[2]) w_slot_row = 2'd2;
        if (w_row_low[1]) w_slot_row = 2'd1;
        if (w_row_low[0]) w_slot_row = 2'd0;
    end

    // Columns are visited in ascending order, so the first slot with a low row is the
    // lowest column; later slots never overwrite the captured code.
    assign w_acc_code_next = (r_acc_cnt == 2'd0 && w_slot_any) ? {w_slot_row, r_col}
                                                                : r_acc_code;
    // Classification includes the column-3 sample taken on the same tick.
    assign w_single = (w_acc_cnt_next == 2'd1);

    // Frame accumulator: updated on each tick, cleared once the frame is classified.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'd0;
        end else if (w_frame_end) begin
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'd0;
        end else if (w_tick) begin
            r_acc_cnt  <= w_acc_cnt_next;
            r_acc_code <= w_acc_code_next;
        end
    end

    // Debounce FSM next-state and outputs; only evaluated at the end of a frame.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_cand_d  = r_cand;
        w_code_d  = r_key_code;
        w_valid_d = 1'b0;
        w_held_d  = r_key_held;
        if (w_frame_end) begin
            case (r_state)
                StIdle: begin
                    if (w_single) begin
                        w_state_d = StDebounce;
                        w_cand_d  = w_acc_code_next;
                        w_cnt_d   = 4'd1;
                    end
                end
                StDebounce: begin
                    if (w_single && (w_acc_code_next == r_cand)) begin
                        if (r_cnt + 4'd1 == DEB_CNT) begin
                            w_state_d = StPressed;
                            w_code_d  = r_cand;
                            w_valid_d = 1'b1;
                            w_held_d  = 1'b1;
                            w_cnt_d   = 4'd0;
                        end else begin
                            w_cnt_d = r_cnt + 4'd1;
                        end
                    end else begin
                        w_state_d = StIdle;
                        w_cnt_d   = 4'd0;
                    end
                end
                StPressed: begin
                    // Any single key keeps the hold; a second key is never reported.
                    if (!w_single) begin
                        w_state_d = StRelease;
                        w_cnt_d   = 4'd1;
                    end
                end
                StRelease: begin
                    if (!w_single) begin
                        if (r_cnt + 4'd1 == DEB_CNT) begin
                            w_state_d = StIdle;
                            w_held_d  = 1'b0;
                            w_cnt_d   = 4'd0;
                        end else begin
                            w_cnt_d = r_cnt + 4'd1;
                        end
                    end else begin
                        w_state_d = StPressed;
                        w_cnt_d   = 4'd0;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Debounce FSM state and registered key outputs.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_cand      <= 4'd0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_cand      <= w_cand_d;
            r_key_code  <= w_code_d;
            r_key_valid <= w_valid_d;
            r_key_held  <= w_held_d;
        end
    end

    assign kp.Key_Code  = r_key_code;
    assign kp.Key_Valid = r_key_valid;
    assign kp.Key_Held  = r_key_held;

endmodule
